// File: rtl/byte_pkg.sv
// Shared definitions for the byte unit.
// Holds the byte-op enumeration, the legal LATENCY bounds, the 11-bit
// opcode encodings, and the decoder that maps an opcode to a byte op.
package byte_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CNTB,
    OP_GBB,
    OP_GB,
    OP_AVGB,
    OP_ABSDB,
    OP_SUMB
  } byte_op_e;

  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 8;

  localparam logic [10:0] OPC_CNTB  = 11'b01010110100;
  localparam logic [10:0] OPC_GBB   = 11'b00110110010;
  localparam logic [10:0] OPC_GB    = 11'b00110110000;
  localparam logic [10:0] OPC_AVGB  = 11'b00011010011;
  localparam logic [10:0] OPC_ABSDB = 11'b00001010011;
  localparam logic [10:0] OPC_SUMB  = 11'b01001010011;

  function automatic byte_op_e decode_op(input logic [10:0] opc);
    case (opc)
      OPC_CNTB:  return OP_CNTB;
      OPC_GBB:   return OP_GBB;
      OPC_GB:    return OP_GB;
      OPC_AVGB:  return OP_AVGB;
      OPC_ABSDB: return OP_ABSDB;
      OPC_SUMB:  return OP_SUMB;
      default:   return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/byte_unit_pipe_lane.sv
// Per-byte datapath for the byte unit.
// Ports: ra_b, rb_b - operand bytes; cnt - popcount of ra_b;
//        avg - rounded average (ra_b + rb_b + 1) >> 1; absd - |rb_b - ra_b|.
module byte_lane (
  input  logic [7:0] ra_b,
  input  logic [7:0] rb_b,
  output logic [7:0] cnt,
  output logic [7:0] avg,
  output logic [7:0] absd
);

  logic [8:0] sum9;

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt = cnt + {7'd0, ra_b[i]};
    end
  end

  // 9-bit sum keeps the carry so 0xFF + 0xFF + 1 rounds to 0xFF.
  assign sum9 = {1'b0, ra_b} + {1'b0, rb_b} + 9'd1;
  assign avg  = sum9[8:1];
  assign absd = (rb_b >= ra_b) ? (rb_b - ra_b) : (ra_b - rb_b);

endmodule

// File: rtl/byte_unit_pipe.sv
// Byte unit pipeline: CNTB, GBB, GB, AVGB, ABSDB, SUMB.
// Ports: clk, reset (async, active-high), unit_reset (sync flush),
//        byte_unit_sel (issue strobe), op_11_even (opcode valid),
//        inst_even[0:31] (opcode [0:10], RT [25:31]), ra/rb operands [0:127],
//        stall (freeze); byte_output, byte_out_availible, byte_addr_rt and
//        illegal_op emerge LATENCY unstalled cycles after acceptance.
// Results are computed into stage 0; later stages only shift.
module byte_unit_pipe
  import byte_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              unit_reset,
  input  logic              byte_unit_sel,
  input  logic              op_11_even,
  input  logic [0:31]       inst_even,
  input  logic [0:127]      ra_data_even,
  input  logic [0:127]      rb_data_even,
  input  logic              stall,
  output logic [0:127]      byte_output,
  output logic              byte_out_availible,
  output logic [ADDR_W-1:0] byte_addr_rt,
  output logic              illegal_op
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("byte_unit_pipe: LATENCY out of range");
  end

  logic                            issue;
  byte_op_e                        op;
  logic [0:127]                    ra_g;
  logic [0:127]                    rb_g;
  logic [0:127]                    res;
  logic [15:0]                     sum_a;
  logic [15:0]                     sum_b;
  logic [7:0]                      cnt_b  [16];
  logic [7:0]                      avg_b  [16];
  logic [7:0]                      absd_b [16];
  logic                            unused_inst_bits;

  logic [LATENCY-1:0]              valid_q, valid_d;
  logic [LATENCY-1:0]              ill_q,   ill_d;
  logic [LATENCY-1:0][0:127]       data_q,  data_d;
  logic [LATENCY-1:0][ADDR_W-1:0]  addr_q,  addr_d;

  assign issue            = byte_unit_sel & ~stall;
  assign op               = op_11_even ? decode_op(inst_even[0:10]) : OP_NONE;
  assign ra_g             = issue ? ra_data_even : '0;
  assign rb_g             = issue ? rb_data_even : '0;
  assign unused_inst_bits = ^inst_even;

  for (genvar i = 0; i < 16; i++) begin : g_lane
    byte_lane u_lane (
      .ra_b (ra_g[8*i +: 8]),
      .rb_b (rb_g[8*i +: 8]),
      .cnt  (cnt_b[i]),
      .avg  (avg_b[i]),
      .absd (absd_b[i])
    );
  end

  always_comb begin
    res   = '0;
    sum_a = '0;
    sum_b = '0;
    case (op)
      OP_CNTB:  for (int unsigned i = 0; i < 16; i++) res[8*i +: 8] = cnt_b[i];
      OP_AVGB:  for (int unsigned i = 0; i < 16; i++) res[8*i +: 8] = avg_b[i];
      OP_ABSDB: for (int unsigned i = 0; i < 16; i++) res[8*i +: 8] = absd_b[i];
      // Bit 7 of a big-endian byte is its LSB.
      OP_GBB:   for (int unsigned i = 0; i < 16; i++) res[16+i] = ra_g[8*i+7];
      OP_GB:    for (int unsigned w = 0; w < 4; w++)  res[28+w] = ra_g[32*w+31];
      OP_SUMB: begin
        for (int unsigned w = 0; w < 4; w++) begin
          sum_a = '0;
          sum_b = '0;
          for (int unsigned b = 0; b < 4; b++) begin
            sum_a = sum_a + {8'd0, ra_g[32*w+8*b +: 8]};
            sum_b = sum_b + {8'd0, rb_g[32*w+8*b +: 8]};
          end
          res[32*w    +: 16] = sum_b;
          res[32*w+16 +: 16] = sum_a;
        end
      end
      default: res = '0;
    endcase
  end

  // unit_reset overrides stall; stall holds every stage.
  always_comb begin
    valid_d = valid_q;
    ill_d   = ill_q;
    data_d  = data_q;
    addr_d  = addr_q;
    if (unit_reset) begin
      valid_d = '0;
      ill_d   = '0;
      data_d  = '0;
      addr_d  = '0;
    end else if (!stall) begin
      valid_d[0] = issue & (op != OP_NONE);
      ill_d[0]   = issue & (op == OP_NONE);
      data_d[0]  = (issue && op != OP_NONE) ? res : '0;
      addr_d[0]  = (issue && op != OP_NONE) ? inst_even[32-ADDR_W +: ADDR_W] : '0;
      for (int unsigned s = 1; s < LATENCY; s++) begin
        valid_d[s] = valid_q[s-1];
        ill_d[s]   = ill_q[s-1];
        data_d[s]  = data_q[s-1];
        addr_d[s]  = addr_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      ill_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ill_q   <= ill_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign byte_output        = data_q[LATENCY-1];
  assign byte_out_availible = valid_q[LATENCY-1];
  assign byte_addr_rt       = addr_q[LATENCY-1];
  assign illegal_op         = ill_q[LATENCY-1];

endmodule
